// File: rtl/jtpang_objdma.sv
// Object DMA sequencer: on a dma_go edge it takes the Z80 bus and copies the
// object table from video RAM into the object engine's private RAM.
module jtpang_objdma #(
    parameter int          AW       = 9,
    parameter logic [11:0] SRC_BASE = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          dma_go,
    output logic          busrq_n,
    input  logic          busak_n,
    output logic [11:0]   vram_addr,
    input  logic [7:0]    vram_dout,
    output logic          own_bus,
    output logic [AW-1:0] obj_addr,
    output logic [7:0]    obj_din,
    output logic          obj_we,
    output logic          busy
);

    // state | meaning
    // IDLE  | bus released, waiting for dma_go edge or pending request
    // REQ   | busrq_n low, waiting for busak_n
    // XFER  | one byte read per cen, written one clk later
    // REL   | drop own_bus and busrq_n
    // WAIT  | waiting for CPU to take the bus back
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] XFER = 3'd2;
    localparam logic [2:0] REL  = 3'd3;
    localparam logic [2:0] WAIT = 3'd4;

    localparam logic [AW-1:0] LAST = {AW{1'b1}};

    logic [2:0]    state_q, state_d;
    logic          dma_go_q;
    logic          start;
    logic          pending_q, pending_d;
    logic          busrq_n_q, busrq_n_d;
    logic          own_bus_q, own_bus_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rd_q, rd_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [11:0]   vram_addr_q;
    logic [AW-1:0] obj_addr_q;
    logic [7:0]    obj_din_q;
    logic          obj_we_q;

    assign start = dma_go & ~dma_go_q;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | start;
        busrq_n_d = busrq_n_q;
        own_bus_d = own_bus_q;
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        rd_d      = 1'b0;
        rd_cnt_d  = rd_cnt_q;
        if (cen) begin
            case (state_q)
                IDLE: begin
                    if (start || pending_q) begin
                        state_d   = REQ;
                        busrq_n_d = 1'b0;
                        busy_d    = 1'b1;
                        pending_d = 1'b0;
                    end
                end
                REQ: begin
                    if (!busak_n) begin
                        state_d   = XFER;
                        own_bus_d = 1'b1;
                        cnt_d     = '0;
                    end
                end
                XFER: begin
                    // Re-acquiring the bus costs one cen so the RAM sees our
                    // address for a full clk before the next read is taken.
                    if (busak_n) begin
                        own_bus_d = 1'b0;
                    end else if (!own_bus_q) begin
                        own_bus_d = 1'b1;
                    end else begin
                        rd_d     = 1'b1;
                        rd_cnt_d = cnt_q;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == LAST) state_d = REL;
                    end
                end
                REL: begin
                    own_bus_d = 1'b0;
                    busrq_n_d = 1'b1;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (busak_n) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // vram_addr always leads the counter so the synchronous RAM output is
    // already valid for the byte being stepped on the current cen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dma_go_q    <= 1'b0;
            pending_q   <= 1'b0;
            busrq_n_q   <= 1'b1;
            own_bus_q   <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            rd_cnt_q    <= '0;
            vram_addr_q <= SRC_BASE;
            obj_addr_q  <= '0;
            obj_din_q   <= 8'h00;
            obj_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            dma_go_q    <= dma_go;
            pending_q   <= pending_d;
            busrq_n_q   <= busrq_n_d;
            own_bus_q   <= own_bus_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            rd_cnt_q    <= rd_cnt_d;
            vram_addr_q <= SRC_BASE + 12'(cnt_d);
            obj_we_q    <= rd_q;
            if (rd_q) begin
                obj_addr_q <= rd_cnt_q;
                obj_din_q  <= vram_dout;
            end
        end
    end

    assign busrq_n   = busrq_n_q;
    assign own_bus   = own_bus_q;
    assign busy      = busy_q;
    assign vram_addr = vram_addr_q;
    assign obj_addr  = obj_addr_q;
    assign obj_din   = obj_din_q;
    assign obj_we    = obj_we_q;

endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: RAM and Z80 bus models around two instances
// (base 0x000 and base 0xF80), write scoreboard plus per-scenario tasks.
module tb_jtpang_objdma;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;
    logic dma_go = 1'b0, busak_n = 1'b1;
    logic busrq_n, own_bus, obj_we, busy;
    logic [11:0] vram_addr;
    logic [7:0]  vram_dout = 8'h00, obj_din;
    logic [8:0]  obj_addr;

    logic dma_go2 = 1'b0, busak2_n = 1'b1;
    logic busrq2_n, own_bus2, obj_we2, busy2;
    logic [11:0] vram_addr2;
    logic [7:0]  vram_dout2 = 8'h00, obj_din2;
    logic [8:0]  obj_addr2;

    int checks = 0, failures = 0, wr_cnt = 0;
    int cen_rate = 1, cen_ph = 0, ack_cnt = 0;
    logic force_off = 1'b0;
    logic [7:0]  vram [4096];
    logic [7:0]  obj_ram [512];
    logic [7:0]  obj_ram2 [512];
    logic [16:0] exp_q [$];
    logic [16:0] exp_e;

    jtpang_objdma #(.AW(9), .SRC_BASE(12'h000)) dut (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go), .busrq_n(busrq_n),
        .busak_n(busak_n), .vram_addr(vram_addr), .vram_dout(vram_dout),
        .own_bus(own_bus), .obj_addr(obj_addr), .obj_din(obj_din),
        .obj_we(obj_we), .busy(busy)
    );

    jtpang_objdma #(.AW(9), .SRC_BASE(12'hF80)) dut2 (
        .clk(clk), .rst(rst), .cen(cen), .dma_go(dma_go2), .busrq_n(busrq2_n),
        .busak_n(busak2_n), .vram_addr(vram_addr2), .vram_dout(vram_dout2),
        .own_bus(own_bus2), .obj_addr(obj_addr2), .obj_din(obj_din2),
        .obj_we(obj_we2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cen_ph = (cen_ph + 1 >= cen_rate) ? 0 : cen_ph + 1;
        cen = (cen_ph == 0);
    end

    // Z80 bus model: acknowledge 3 cen after request, release next clk.
    always @(posedge clk) begin
        logic cen_now;
        cen_now = cen;
        #1;
        if (busrq_n) begin
            busak_n = 1'b1;
            ack_cnt = 0;
        end else if (force_off) begin
            busak_n = 1'b1;
            ack_cnt = 3;
        end else if (busak_n) begin
            if (ack_cnt >= 3) busak_n = 1'b0;
            else if (cen_now) ack_cnt++;
        end
        busak2_n = busrq2_n;
    end

    always @(posedge clk) begin
        vram_dout  <= vram[own_bus  ? vram_addr  : 12'h000];
        vram_dout2 <= vram[own_bus2 ? vram_addr2 : 12'h000];
        if (obj_we)  obj_ram[obj_addr]   <= obj_din;
        if (obj_we2) obj_ram2[obj_addr2] <= obj_din2;
    end

    always @(negedge clk) begin
        if (!rst && obj_we) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_write addr=%h data=%h", obj_addr, obj_din);
            end else begin
                exp_e = exp_q.pop_front();
                if ({obj_addr, obj_din} !== exp_e) begin
                    failures++;
                    $display("FAIL sb_write got addr=%h data=%h want addr=%h data=%h",
                             obj_addr, obj_din, exp_e[16:8], exp_e[7:0]);
                end
            end
        end
    end

    task automatic push_copy();
        for (int i = 0; i < 512; i++) exp_q.push_back({9'(i), vram[12'(i)]});
    endtask

    task automatic pulse_go();
        @(posedge clk); #1 dma_go = 1'b1;
        @(posedge clk); #1 dma_go = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 30000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && busrq_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_write(input logic [8:0] a, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (obj_we && obj_addr == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_mism(output int m);
        m = 0;
        for (int i = 0; i < 512; i++) if (obj_ram[i] !== vram[i]) m++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busrq_n !== 1'b1) begin failures++; $display("FAIL reset_busrq_n got=%b want=1", busrq_n); end
        checks++; if (own_bus !== 1'b0) begin failures++; $display("FAIL reset_own_bus got=%b want=0", own_bus); end
        checks++; if (obj_we !== 1'b0) begin failures++; $display("FAIL reset_obj_we got=%b want=0", obj_we); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (vram_addr !== 12'h000) begin failures++; $display("FAIL reset_vram_addr got=%h want=000", vram_addr); end
        checks++; if (vram_addr2 !== 12'hF80) begin failures++; $display("FAIL reset_vram_addr2 got=%h want=f80", vram_addr2); end
        checks++; if ({obj_addr, obj_din} !== 17'h0) begin failures++; $display("FAIL reset_obj_bus got=%h want=0", {obj_addr, obj_din}); end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int base, m;
        for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
        base = wr_cnt;
        push_copy();
        @(posedge clk); #1 dma_go = 1'b1;
        @(negedge clk);
        checks++; if (busrq_n !== 1'b1) begin failures++; $display("FAIL basic_busrq_early got=%b want=1", busrq_n); end
        @(negedge clk);
        checks++; if (busrq_n !== 1'b0) begin failures++; $display("FAIL basic_busrq_fall got=%b want=0", busrq_n); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", busy); end
        @(posedge clk); #1 dma_go = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d want=done", exp_q.size()); end
        checks++; if (wr_cnt - base !== 512) begin failures++; $display("FAIL basic_writes got=%0d want=512", wr_cnt - base); end
        count_mism(m);
        checks++; if (m !== 0) begin failures++; $display("FAIL basic_copy got=%0d bad want=0", m); end
        checks++; if (own_bus !== 1'b0) begin failures++; $display("FAIL basic_own_bus got=%b want=0", own_bus); end
    endtask

    task automatic test_wrap();
        bit seen;
        bit done;
        seen = 1'b0;
        done = 1'b0;
        @(posedge clk); #1 dma_go2 = 1'b1;
        @(posedge clk); #1 dma_go2 = 1'b0;
        for (int c = 0; c < 5000 && !done; c++) begin
            @(negedge clk);
            if (busy2) seen = 1'b1;
            else if (seen && busrq2_n) done = 1'b1;
        end
        checks++; if (!done) begin failures++; $display("FAIL wrap_timeout got=busy want=done"); end
        checks++; if (obj_ram2[9'h080] !== vram[12'h000]) begin failures++; $display("FAIL wrap_080 got=%h want=%h", obj_ram2[9'h080], vram[12'h000]); end
        checks++; if (obj_ram2[9'h000] !== vram[12'hF80]) begin failures++; $display("FAIL wrap_000 got=%h want=%h", obj_ram2[9'h000], vram[12'hF80]); end
        checks++; if (obj_ram2[9'h1FF] !== vram[12'h17F]) begin failures++; $display("FAIL wrap_1ff got=%h want=%h", obj_ram2[9'h1FF], vram[12'h17F]); end
    endtask

    task automatic test_bus_loss();
        bit ok;
        int base, snap, m;
        for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
        base = wr_cnt;
        push_copy();
        pulse_go();
        wait_write(9'd99, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loss_reach got=timeout want=write99"); end
        force_off = 1'b1;
        repeat (3) @(negedge clk);
        snap = wr_cnt;
        repeat (10) @(negedge clk);
        checks++; if (wr_cnt !== snap) begin failures++; $display("FAIL loss_gap_writes got=%0d want=0", wr_cnt - snap); end
        checks++; if (own_bus !== 1'b0) begin failures++; $display("FAIL loss_own_bus got=%b want=0", own_bus); end
        checks++; if (busrq_n !== 1'b0) begin failures++; $display("FAIL loss_busrq_n got=%b want=0", busrq_n); end
        force_off = 1'b0;
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL loss_timeout got=%0d want=done", exp_q.size()); end
        checks++; if (wr_cnt - base !== 512) begin failures++; $display("FAIL loss_writes got=%0d want=512", wr_cnt - base); end
        count_mism(m);
        checks++; if (m !== 0) begin failures++; $display("FAIL loss_copy got=%0d bad want=0", m); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base, m;
        for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
        base = wr_cnt;
        push_copy();
        pulse_go();
        for (int c = 0; c < 2000 && wr_cnt - base < 50; c++) @(negedge clk);
        pulse_go();
        repeat (5) @(posedge clk);
        pulse_go();
        push_copy();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d want=done", exp_q.size()); end
        repeat (20) @(negedge clk);
        checks++; if (wr_cnt - base !== 1024) begin failures++; $display("FAIL b2b_writes got=%0d want=1024", wr_cnt - base); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_extra_busy got=%b want=0", busy); end
        count_mism(m);
        checks++; if (m !== 0) begin failures++; $display("FAIL b2b_copy got=%0d bad want=0", m); end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int base, m;
        for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
        push_copy();
        pulse_go();
        wait_write(9'd199, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_reach got=timeout want=write199"); end
        rst = 1'b1;
        #1;
        checks++; if (busrq_n !== 1'b1) begin failures++; $display("FAIL rstmid_busrq_n got=%b want=1", busrq_n); end
        checks++; if (own_bus !== 1'b0) begin failures++; $display("FAIL rstmid_own_bus got=%b want=0", own_bus); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int a = 0; a < 4096; a++) vram[a] = 8'($urandom);
        base = wr_cnt;
        push_copy();
        pulse_go();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got=%0d want=done", exp_q.size()); end
        checks++; if (wr_cnt - base !== 512) begin failures++; $display("FAIL rstmid_writes got=%0d want=512", wr_cnt - base); end
        count_mism(m);
        checks++; if (m !== 0) begin failures++; $display("FAIL rstmid_copy got=%0d bad want=0", m); end
    endtask

    task automatic test_slow_cen();
        bit ok;
        int base, m;
        cen_rate = 8;
        for (int a = 0; a < 4096; a++) vram[a] = 8'(a) ^ 8'h5A;
        base = wr_cnt;
        push_copy();
        pulse_go();
        wait_done(ok);
        checks++; if (!ok) begin failures++; $display("FAIL slow_timeout got=%0d want=done", exp_q.size()); end
        checks++; if (wr_cnt - base !== 512) begin failures++; $display("FAIL slow_writes got=%0d want=512", wr_cnt - base); end
        count_mism(m);
        checks++; if (m !== 0) begin failures++; $display("FAIL slow_copy got=%0d bad want=0", m); end
        cen_rate = 1;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) vram[a] = 8'h00;
        test_reset();
        test_basic();
        test_wrap();
        test_bus_loss();
        test_back_to_back();
        test_rst_mid();
        test_slow_cen();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
